// File: rtl/flash_apb_arbiter.sv
// rtl/flash_apb_arbiter.sv - two-requester round-robin arbiter onto a flash-controller APB port
module flash_apb_arbiter #(
   parameter int LINEWIDE      = 32,
   parameter int ACCESS_CYCLES = 4
) (
   input  logic                p_clk,
   input  logic                p_rst,
   input  logic                r0_req,
   input  logic                r0_write,
   input  logic [LINEWIDE-1:0] r0_addr,
   input  logic [LINEWIDE-1:0] r0_wdata,
   output logic                r0_ack,
   output logic [LINEWIDE-1:0] r0_rdata,
   input  logic                r1_req,
   input  logic                r1_write,
   input  logic [LINEWIDE-1:0] r1_addr,
   input  logic [LINEWIDE-1:0] r1_wdata,
   output logic                r1_ack,
   output logic [LINEWIDE-1:0] r1_rdata,
   output logic                p_sel_x,
   output logic                p_enable,
   output logic                p_write,
   output logic [LINEWIDE-1:0] p_addr,
   output logic [LINEWIDE-1:0] p_wdata,
   input  logic [LINEWIDE-1:0] p_rdata,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Value loaded into the access counter so the enable phase lasts ACCESS_CYCLES cycles.
   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t              state_q, state_d;
   logic                sel_q, sel_d;
   logic                en_q, en_d;
   logic                write_q, write_d;
   logic [LINEWIDE-1:0] addr_q, addr_d;
   logic [LINEWIDE-1:0] wdata_q, wdata_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic [LINEWIDE-1:0] rdata0_q, rdata0_d;
   logic [LINEWIDE-1:0] rdata1_q, rdata1_d;
   logic                busy_q, busy_d;
   logic                last_q, last_d;   // index of the requester granted most recently
   logic                grant_q, grant_d; // index of the requester owning the current transfer
   logic [3:0]          cnt_q, cnt_d;
   logic                pick;

   // Next-state and registered-output computation; every output is a flop fed from here.
   always_comb begin
      state_d  = state_q;
      sel_d    = 1'b0;
      en_d     = 1'b0;
      write_d  = write_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      last_d   = last_q;
      grant_d  = grant_q;
      cnt_d    = cnt_q;
      pick     = 1'b0;

      case (state_q)
         IDLE: begin
            if (r0_req || r1_req) begin
               // Contention goes to whoever was not served last; a lone request always wins.
               pick    = (r0_req && r1_req) ? ~last_q : r1_req;
               grant_d = pick;
               last_d  = pick;
               write_d = pick ? r1_write : r0_write;
               addr_d  = pick ? r1_addr  : r0_addr;
               wdata_d = pick ? r1_wdata : r0_wdata;
               sel_d   = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            sel_d   = 1'b1;
            en_d    = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               // Last enable cycle: read data from the controller is valid now.
               if (!write_q) begin
                  if (grant_q) rdata1_d = p_rdata;
                  else         rdata0_d = p_rdata;
               end
               ack0_d  = ~grant_q;
               ack1_d  = grant_q;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               sel_d = 1'b1;
               en_d  = 1'b1;
            end
         end
         DONE: begin
            // Always return to IDLE so back-to-back transfers are separated by an idle cycle.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset that also aborts any transfer.
   always_ff @(posedge p_clk) begin
      if (p_rst) begin
         state_q  <= IDLE;
         sel_q    <= 1'b0;
         en_q     <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         busy_q   <= 1'b0;
         last_q   <= 1'b1;
         grant_q  <= 1'b0;
         cnt_q    <= 4'd0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         en_q     <= en_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         busy_q   <= busy_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
      end
   end

   assign p_sel_x  = sel_q;
   assign p_enable = en_q;
   assign p_write  = write_q;
   assign p_addr   = addr_q;
   assign p_wdata  = wdata_q;
   assign r0_ack   = ack0_q;
   assign r1_ack   = ack1_q;
   assign r0_rdata = rdata0_q;
   assign r1_rdata = rdata1_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_flash_apb_arbiter.sv
// tb/tb_flash_apb_arbiter.sv - directed scoreboard bench for flash_apb_arbiter
module tb_flash_apb_arbiter;

   logic        p_clk = 1'b0;
   logic        p_rst;
   logic [31:0] p_rdata;

   logic        r0_req, r0_write, r1_req, r1_write;
   logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic        r0_ack, r1_ack;
   logic [31:0] r0_rdata, r1_rdata;
   logic        p_sel_x, p_enable, p_write, busy;
   logic [31:0] p_addr, p_wdata;

   logic        b_r0_req, b_r0_write, b_r1_req, b_r1_write;
   logic [31:0] b_r0_addr, b_r0_wdata, b_r1_addr, b_r1_wdata;
   logic        b_r0_ack, b_r1_ack;
   logic [31:0] b_r0_rdata, b_r1_rdata;
   logic        b_p_sel_x, b_p_enable, b_p_write, b_busy;
   logic [31:0] b_p_addr, b_p_wdata;

   typedef struct {
      int          who;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] mr [2];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 p_clk = ~p_clk;

   flash_apb_arbiter #(.LINEWIDE(32), .ACCESS_CYCLES(4)) u_dut (
      .p_clk(p_clk), .p_rst(p_rst),
      .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ack(r0_ack), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ack(r1_ack), .r1_rdata(r1_rdata),
      .p_sel_x(p_sel_x), .p_enable(p_enable), .p_write(p_write),
      .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata), .busy(busy)
   );

   flash_apb_arbiter #(.LINEWIDE(32), .ACCESS_CYCLES(1)) u_dut1 (
      .p_clk(p_clk), .p_rst(p_rst),
      .r0_req(b_r0_req), .r0_write(b_r0_write), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
      .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
      .r1_req(b_r1_req), .r1_write(b_r1_write), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
      .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
      .p_sel_x(b_p_sel_x), .p_enable(b_p_enable), .p_write(b_p_write),
      .p_addr(b_p_addr), .p_wdata(b_p_wdata), .p_rdata(p_rdata), .busy(b_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge p_clk);
      #1;
   endtask

   task automatic push(input int who, input logic wr);
      exp_t e;
      if (!wr) mr[who] = p_rdata;
      e.who   = who;
      e.rdata = mr[who];
      sb.push_back(e);
   endtask

   task automatic xfer(input int who, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int exp_lat);
      int n = 0;
      if (who == 0) begin
         r0_req = 1'b1; r0_write = wr; r0_addr = addr; r0_wdata = wdata;
      end else begin
         r1_req = 1'b1; r1_write = wr; r1_addr = addr; r1_wdata = wdata;
      end
      push(who, wr);
      do begin
         tick();
         n++;
      end while (!((who == 0) ? r0_ack : r1_ack) && n < 20);
      chk("xfer_latency", n, exp_lat);
      r0_req = 1'b0;
      r1_req = 1'b0;
      tick();
      chk("xfer_idle_after", busy, 1'b0);
   endtask

   // Protocol invariants every cycle, plus scoreboard pop on each completion pulse.
   always @(negedge p_clk) begin
      chk("proto_two_acks", r0_ack & r1_ack, 1'b0);
      chk("proto_en_no_sel", p_enable & ~p_sel_x, 1'b0);
      chk("proto1_two_acks", b_r0_ack & b_r1_ack, 1'b0);
      chk("proto1_en_no_sel", b_p_enable & ~b_p_sel_x, 1'b0);
      if (r0_ack || r1_ack) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", {r1_ack, r0_ack}, 2'b00);
         end else begin
            mon_e = sb.pop_front();
            chk("ack_who", r1_ack ? 1 : 0, mon_e.who);
            chk("ack_rdata", (mon_e.who == 1) ? r1_rdata : r0_rdata, mon_e.rdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      p_rst = 1'b1; p_rdata = '0;
      r0_req = 0; r0_write = 0; r0_addr = '0; r0_wdata = '0;
      r1_req = 0; r1_write = 0; r1_addr = '0; r1_wdata = '0;
      b_r0_req = 0; b_r0_write = 0; b_r0_addr = '0; b_r0_wdata = '0;
      b_r1_req = 0; b_r1_write = 0; b_r1_addr = '0; b_r1_wdata = '0;
      mr[0] = '0; mr[1] = '0;
      tick();
      tick();
      chk("rst_sel", p_sel_x, 1'b0);
      chk("rst_en", p_enable, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_addr", p_addr, 32'h0);
      chk("rst_wdata", p_wdata, 32'h0);
      chk("rst_rdata0", r0_rdata, 32'h0);
      chk("rst_rdata1", r1_rdata, 32'h0);
      p_rst = 1'b0;

      // Single write from requester 0.
      r0_req = 1; r0_write = 1; r0_addr = 32'h0; r0_wdata = 32'hFF00FF00;
      push(0, 1'b1);
      tick();
      chk("wr_setup_sel", p_sel_x, 1'b1);
      chk("wr_setup_en", p_enable, 1'b0);
      chk("wr_setup_busy", busy, 1'b1);
      chk("wr_setup_wdata", p_wdata, 32'hFF00FF00);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wr_acc_en", p_enable, 1'b1);
         chk("wr_acc_wdata", p_wdata, 32'hFF00FF00);
         chk("wr_acc_write", p_write, 1'b1);
      end
      tick();
      chk("wr_ack6", r0_ack, 1'b1);
      chk("wr_done_sel", p_sel_x, 1'b0);
      r0_req = 0;
      tick();
      chk("wr_ack_pulse", r0_ack, 1'b0);
      chk("wr_idle_busy", busy, 1'b0);
      chk("wr_hold_wdata", p_wdata, 32'hFF00FF00);

      // Reads to each requester and a write that must not disturb read data.
      p_rdata = 32'h12345678;
      xfer(1, 1'b0, 32'h10, 32'h0, 6);
      chk("rd1_rdata", r1_rdata, 32'h12345678);
      chk("rd1_r0_untouched", r0_rdata, 32'h0);
      p_rdata = 32'hA5A55A5A;
      xfer(0, 1'b0, 32'h4, 32'h0, 6);
      chk("rd0_rdata", r0_rdata, 32'hA5A55A5A);
      chk("rd0_r1_held", r1_rdata, 32'h12345678);
      xfer(1, 1'b1, 32'h8, 32'hDEADBEEF, 6);
      chk("wr1_r1_held", r1_rdata, 32'h12345678);
      chk("wr1_addr_hold", p_addr, 32'h8);

      // Contention after reset alternates r0, r1, r0, r1.
      p_rst = 1'b1;
      tick();
      p_rst = 1'b0;
      mr[0] = '0; mr[1] = '0;
      chk("rst2_rdata1", r1_rdata, 32'h0);
      r0_req = 1; r0_write = 1; r0_addr = 32'h20; r0_wdata = 32'h1111;
      r1_req = 1; r1_write = 1; r1_addr = 32'h24; r1_wdata = 32'h2222;
      push(0, 1'b1); push(1, 1'b1); push(0, 1'b1); push(1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!(r0_ack || r1_ack) && n < 20);
         chk("rr_lat", n, 6);
         chk("rr_who", r1_ack, (k % 2) == 1);
         if (k == 3) begin
            r0_req = 0; r1_req = 0;
         end
         tick();
         chk("rr_idle_gap", busy, 1'b0);
      end

      // Reset in the second access cycle aborts with no ack.
      p_rdata = 32'h77;
      r1_req = 1; r1_write = 0; r1_addr = 32'h30;
      tick();
      tick();
      tick();
      chk("abort_in_access", p_enable, 1'b1);
      p_rst = 1'b1; r1_req = 0;
      tick();
      chk("abort_sel", p_sel_x, 1'b0);
      chk("abort_en", p_enable, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_rdata1", r1_rdata, 32'h0);
      p_rst = 1'b0;
      mr[0] = '0; mr[1] = '0;
      tick(); tick(); tick();
      r0_req = 1; r0_write = 1; r1_req = 1; r1_write = 1;
      push(0, 1'b1);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(r0_ack || r1_ack) && n < 20);
      chk("post_rst_winner", r0_ack, 1'b1);
      r0_req = 0; r1_req = 0;
      tick();

      // Requester drops its request during SETUP.
      r0_req = 1; r0_write = 1; r0_wdata = 32'h5A5A;
      push(0, 1'b1);
      tick();
      chk("drop_setup_busy", busy, 1'b1);
      r0_req = 0;
      n = 1;
      do begin
         tick();
         n++;
      end while (!r0_ack && n < 20);
      chk("drop_lat", n, 6);
      tick();
      chk("drop_ack_once", r0_ack, 1'b0);
      chk("drop_idle", busy, 1'b0);
      tick(); tick();

      // Single-cycle access phase instance.
      p_rdata = 32'hCAFEF00D;
      b_r1_req = 1; b_r1_write = 0; b_r1_addr = 32'h40;
      n = 0;
      do begin
         tick();
         n++;
      end while (!b_r1_ack && n < 20);
      chk("ac1_rd_lat", n, 3);
      chk("ac1_rdata", b_r1_rdata, 32'hCAFEF00D);
      b_r1_req = 0;
      tick();
      chk("ac1_idle", b_busy, 1'b0);
      b_r0_req = 1; b_r0_write = 1; b_r0_wdata = 32'h0BADC0DE;
      tick();
      chk("ac1_wr_wdata", b_p_wdata, 32'h0BADC0DE);
      n = 1;
      do begin
         tick();
         n++;
      end while (!b_r0_ack && n < 20);
      chk("ac1_wr_lat", n, 3);
      chk("ac1_wr_rdata_held", b_r0_rdata, 32'h0);
      b_r0_req = 0;
      tick();
      tick();
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
